carus_sram_arbiter: RTL and testbench
=====================================

CARUS_SRAM_ARBITER -- requirements
Module: carus_sram_arbiter

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 1024: words in the attached bank; AddrWidth = clog2(NUM_WORDS), minimum 1.
REQ-002 SHALL have parameter IDLE_CYCLES, default 16: consecutive idle cycles before retention entry; legal range 2..255.
REQ-003 SHALL have parameter WAKE_CYCLES, default 2: cycles between retention exit and the first grant; legal range 1..15.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk_i input 1 (clock); rst_i input 1 (async reset, active high).
REQ-005 SHALL have port pX_req_i input 1: request, for X = 0 (system bus) and X = 1 (vector engine).
REQ-006 SHALL have port pX_we_i input 1: write enable.
REQ-007 SHALL have port pX_addr_i input AddrWidth: word address.
REQ-008 SHALL have port pX_wdata_i input 32: write data.
REQ-009 SHALL have port pX_be_i input 4: byte enables.
REQ-010 SHALL have port pX_gnt_o output 1: request accepted this cycle.
REQ-011 SHALL have port pX_rvalid_o output 1: response valid.
REQ-012 SHALL have port pX_rdata_o output 32: read data.
REQ-013 SHALL have port ret_en_i input 1: allow retention entry.
REQ-014 SHALL have port mem_req_o output 1 and mem_we_o output 1.
REQ-015 SHALL have port mem_addr_o output AddrWidth, mem_wdata_o output 32 and mem_be_o output 4.
REQ-016 SHALL have port mem_set_retentive_no output 1: 0 = bank in retention.
REQ-017 SHALL have port mem_rdata_i input 32: bank read data, valid one cycle after mem_req_o.
REQ-018 SHALL have port ret_state_o output 1: high while in RETENTIVE or WAKE.

Function
REQ-019 SHALL use FSM states ACTIVE, RETENTIVE and WAKE; grants are issued only in ACTIVE.
REQ-020 SHALL, in ACTIVE, grant combinationally in the same cycle as req: one requester gets it unconditionally; when both request, the port selected by the round-robin pointer gets it.
REQ-021 SHALL toggle the round-robin pointer to the non-granted port only on a contended grant, and reset the pointer to port 0.
REQ-022 SHALL drive mem_req_o = gnt0|gnt1 and mux mem_we/addr/wdata/be from the granted port; all mem_* outputs SHALL be 0 when no grant is issued.
REQ-023 SHALL assert pX_rvalid_o exactly one cycle after every pX_gnt_o, for both reads and writes.
REQ-024 SHALL drive pX_rdata_o = mem_rdata_i when rvalid is for a read and 0 otherwise; the owner and read flag SHALL be registered at grant time.
REQ-025 SHALL use an 8-bit idle counter: clear on any pX_req_i, increment in ACTIVE when no request is present, saturate at IDLE_CYCLES.
REQ-026 SHALL transition ACTIVE to RETENTIVE when the idle counter equals IDLE_CYCLES, ret_en_i = 1 and no rvalid is pending; mem_set_retentive_no SHALL go 0 in the next cycle.
REQ-027 SHALL, in RETENTIVE, leave the idle counter unchanged.
REQ-028 SHALL transition RETENTIVE to WAKE on any pX_req_i or ret_en_i = 0; mem_set_retentive_no SHALL return to 1 upon entering WAKE.
REQ-029 SHALL, in WAKE, count WAKE_CYCLES with a 4-bit counter, then return to ACTIVE with the idle counter cleared.
REQ-030 SHALL hold requests presented in RETENTIVE or WAKE with gnt = 0; requesters keep req high, per the handshake rule.
REQ-031 SHALL evaluate the transition to RETENTIVE after arbitration: a request present in the same cycle always wins and the FSM stays in ACTIVE.
REQ-032 SHALL accept back-to-back grants to the same port every cycle without bubbles.

Reset
REQ-033 SHALL, while rst_i = 1, asynchronously set the state to ACTIVE, both counters to 0, the pointer to 0, rvalid regs to 0, and mem_set_retentive_no to 1.
REQ-034 SHALL drop an in-flight rvalid when reset is asserted mid-operation; after reset, no response SHALL appear for a pre-reset grant.

Structure
REQ-035 SHALL place the FSM state enum and the counter width constants in the shared package carus_pkg.
REQ-036 SHALL instantiate one sub-module, carus_rr_arbiter_2: a two-input round-robin grant with a pointer register.

Verification
REQ-037 SHALL cover: p0 read addr 0x10 alone -> gnt0 in the same cycle, rvalid0 next cycle, rdata0 = mem_rdata_i.
REQ-038 SHALL cover: p0 and p1 requesting for 4 cycles after reset -> grants p0, p1, p0, p1.
REQ-039 SHALL cover: no request for 16 cycles with ret_en_i = 1 -> mem_set_retentive_no = 0 on cycle 18 and ret_state_o = 1.
REQ-040 SHALL cover: in RETENTIVE, p1 write -> WAKE for 2 cycles, gnt1 on the 3rd cycle after req, rvalid1 one cycle later with rdata1 = 0.
REQ-041 SHALL cover: p0 req asserted in the cycle the idle counter reaches 16 -> gnt0 issued and the FSM stays in ACTIVE.
REQ-042 SHALL cover: rst_i asserted the cycle after gnt0 (read) -> rvalid0 stays 0 and all outputs are at their reset values.

Source files
------------

// File: rtl/carus_pkg.sv
// carus_pkg
// Shared types and constants for the Carus SRAM arbiter slice.
//   carus_state_e : power-management FSM states of the bank arbiter
//   IdleCntWidth  : width of the idle counter that times retention entry
//   WakeCntWidth  : width of the counter that times retention exit
package carus_pkg;

  localparam int IdleCntWidth = 8;
  localparam int WakeCntWidth = 4;

  typedef enum logic [1:0] {
    ST_ACTIVE    = 2'd0,
    ST_RETENTIVE = 2'd1,
    ST_WAKE      = 2'd2
  } carus_state_e;

endpackage

// File: rtl/carus_rr_arbiter_2.sv
// carus_rr_arbiter_2
// Two-input round-robin grant with a one-bit priority pointer.
// Ports:
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   en_i             : grants are only issued while high
//   req0_i, req1_i   : requests
//   gnt0_o, gnt1_o   : combinational grants (same cycle as the request)
module carus_rr_arbiter_2
  import carus_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  // Pointer selects the favoured port when both request; 0 = port 0.
  logic ptr_q, ptr_d;

  // A lone requester always wins; on contention the pointer decides and
  // then moves to the loser so the next contended grant goes the other way.
  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    ptr_d  = ptr_q;
    if (en_i) begin
      if (req0_i && req1_i) begin
        if (!ptr_q) begin
          gnt0_o = 1'b1;
          ptr_d  = 1'b1;
        end else begin
          gnt1_o = 1'b1;
          ptr_d  = 1'b0;
        end
      end else begin
        gnt0_o = req0_i;
        gnt1_o = req1_i;
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/carus_sram_arbiter.sv
// carus_sram_arbiter
// Arbitrates a system-bus port (p0) and a vector-engine port (p1) onto a
// single SRAM bank, and puts the bank into retention after a run of idle
// cycles.
// Ports:
//   clk_i, rst_i                : clock, asynchronous active-high reset
//   pX_req/we/addr/wdata/be_i   : requester X command (X = 0, 1)
//   pX_gnt_o                    : command accepted this cycle
//   pX_rvalid_o, pX_rdata_o     : response one cycle after the grant
//   ret_en_i                    : permits retention entry
//   mem_req/we/addr/wdata/be_o  : bank command (all zero without a grant)
//   mem_rdata_i                 : bank read data, one cycle after mem_req_o
//   mem_set_retentive_no        : 0 while the bank is in retention
//   ret_state_o                 : high while in RETENTIVE or WAKE
module carus_sram_arbiter
  import carus_pkg::*;
#(
  parameter int NUM_WORDS   = 1024,
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  localparam int AddrWidth  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 p0_req_i,
  input  logic                 p0_we_i,
  input  logic [AddrWidth-1:0] p0_addr_i,
  input  logic [31:0]          p0_wdata_i,
  input  logic [3:0]           p0_be_i,
  output logic                 p0_gnt_o,
  output logic                 p0_rvalid_o,
  output logic [31:0]          p0_rdata_o,
  input  logic                 p1_req_i,
  input  logic                 p1_we_i,
  input  logic [AddrWidth-1:0] p1_addr_i,
  input  logic [31:0]          p1_wdata_i,
  input  logic [3:0]           p1_be_i,
  output logic                 p1_gnt_o,
  output logic                 p1_rvalid_o,
  output logic [31:0]          p1_rdata_o,
  input  logic                 ret_en_i,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  output logic [3:0]           mem_be_o,
  output logic                 mem_set_retentive_no,
  input  logic [31:0]          mem_rdata_i,
  output logic                 ret_state_o
);

  localparam logic [IdleCntWidth-1:0] IdleMax  = IDLE_CYCLES[IdleCntWidth-1:0];
  localparam logic [WakeCntWidth-1:0] WakeLast = WakeCntWidth'(WAKE_CYCLES - 1);

  carus_state_e            state_q, state_d;
  logic [IdleCntWidth-1:0] idle_q, idle_d;
  logic [WakeCntWidth-1:0] wake_q, wake_d;
  logic                    ret_no_q;
  logic                    rvalid0_q, rvalid1_q;
  logic                    read_q;
  logic                    gnt0, gnt1;
  logic                    any_req;

  assign any_req = p0_req_i | p1_req_i;

  carus_rr_arbiter_2 u_rr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (state_q == ST_ACTIVE),
    .req0_i (p0_req_i),
    .req1_i (p1_req_i),
    .gnt0_o (gnt0),
    .gnt1_o (gnt1)
  );

  assign p0_gnt_o = gnt0;
  assign p1_gnt_o = gnt1;

  // Bank command mux: the granted port drives the bank, otherwise all zero.
  always_comb begin
    mem_req_o   = gnt0 | gnt1;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (gnt0) begin
      mem_we_o    = p0_we_i;
      mem_addr_o  = p0_addr_i;
      mem_wdata_o = p0_wdata_i;
      mem_be_o    = p0_be_i;
    end else if (gnt1) begin
      mem_we_o    = p1_we_i;
      mem_addr_o  = p1_addr_i;
      mem_wdata_o = p1_wdata_i;
      mem_be_o    = p1_be_i;
    end
  end

  // Power FSM and its counters. Retention entry is only taken when nothing
  // requests, so a request arriving on the threshold cycle is still served.
  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    wake_d  = wake_q;
    unique case (state_q)
      ST_ACTIVE: begin
        if (any_req)               idle_d = '0;
        else if (idle_q < IdleMax) idle_d = idle_q + 1'b1;
        if (!any_req && (idle_q == IdleMax) && ret_en_i && !rvalid0_q && !rvalid1_q)
          state_d = ST_RETENTIVE;
      end
      ST_RETENTIVE: begin
        if (any_req || !ret_en_i) begin
          state_d = ST_WAKE;
          wake_d  = '0;
        end
      end
      ST_WAKE: begin
        if (any_req) idle_d = '0;
        if (wake_q == WakeLast) begin
          state_d = ST_ACTIVE;
          wake_d  = '0;
          idle_d  = '0;
        end else begin
          wake_d = wake_q + 1'b1;
        end
      end
      default: state_d = ST_ACTIVE;
    endcase
  end

  // State, counters, retention pin and response tracking. The read flag is
  // shared because at most one port is granted per cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_ACTIVE;
      idle_q    <= '0;
      wake_q    <= '0;
      ret_no_q  <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      read_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idle_q    <= idle_d;
      wake_q    <= wake_d;
      ret_no_q  <= (state_d != ST_RETENTIVE);
      rvalid0_q <= gnt0;
      rvalid1_q <= gnt1;
      read_q    <= (gnt0 & ~p0_we_i) | (gnt1 & ~p1_we_i);
    end
  end

  assign mem_set_retentive_no = ret_no_q;
  assign ret_state_o          = (state_q != ST_ACTIVE);
  assign p0_rvalid_o          = rvalid0_q;
  assign p1_rvalid_o          = rvalid1_q;
  assign p0_rdata_o           = (rvalid0_q && read_q) ? mem_rdata_i : 32'h0;
  assign p1_rdata_o           = (rvalid1_q && read_q) ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_carus_sram_arbiter.sv
// tb_carus_sram_arbiter
// Directed scenarios followed by a bursty random phase. Every cycle the DUT
// outputs are compared with a cycle-level reference model of the arbiter
// and its power states, kept in plain integers.
module tb_carus_sram_arbiter;

  localparam int NW = 1024;
  localparam int IC = 16;
  localparam int WC = 2;
  localparam int AW = 10;

  localparam int M_ACTIVE = 0;
  localparam int M_RET    = 1;
  localparam int M_WAKE   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          p0Req = 0, p0We = 0, p1Req = 0, p1We = 0, retEn = 0;
  logic [AW-1:0] p0Addr = '0, p1Addr = '0;
  logic [31:0]   p0Wdata = '0, p1Wdata = '0, memRdata = '0;
  logic [3:0]    p0Be = '0, p1Be = '0;
  logic          p0Gnt, p1Gnt, p0Rvalid, p1Rvalid;
  logic [31:0]   p0Rdata, p1Rdata;
  logic          memReq, memWe, memRetNo, retState;
  logic [AW-1:0] memAddr;
  logic [31:0]   memWdata;
  logic [3:0]    memBe;

  carus_sram_arbiter #(
    .NUM_WORDS   (NW),
    .IDLE_CYCLES (IC),
    .WAKE_CYCLES (WC)
  ) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .p0_req_i             (p0Req),
    .p0_we_i              (p0We),
    .p0_addr_i            (p0Addr),
    .p0_wdata_i           (p0Wdata),
    .p0_be_i              (p0Be),
    .p0_gnt_o             (p0Gnt),
    .p0_rvalid_o          (p0Rvalid),
    .p0_rdata_o           (p0Rdata),
    .p1_req_i             (p1Req),
    .p1_we_i              (p1We),
    .p1_addr_i            (p1Addr),
    .p1_wdata_i           (p1Wdata),
    .p1_be_i              (p1Be),
    .p1_gnt_o             (p1Gnt),
    .p1_rvalid_o          (p1Rvalid),
    .p1_rdata_o           (p1Rdata),
    .ret_en_i             (retEn),
    .mem_req_o            (memReq),
    .mem_we_o             (memWe),
    .mem_addr_o           (memAddr),
    .mem_wdata_o          (memWdata),
    .mem_be_o             (memBe),
    .mem_set_retentive_no (memRetNo),
    .mem_rdata_i          (memRdata),
    .ret_state_o          (retState)
  );

  always #5 clk = ~clk;

  int evals = 0;
  int fails = 0;

  // Reference model state
  int mMode, mIdle, mWakeLeft, mPtr;
  bit mPend0, mPend1, mRead0, mRead1;
  bit expGnt0, expGnt1;

  // Last observed values, used by the directed scenarios
  logic        lastGnt0, lastGnt1, lastRvalid0, lastRvalid1, lastRetNo, lastRetState;
  logic [31:0] lastRdata0, lastRdata1, lastMemRdata;
  logic [AW-1:0] lastAddr;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    evals++;
    assert (observed === expected)
      else begin
        fails++;
        $error("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
      end
  endtask

  task automatic modelReset();
    mMode = M_ACTIVE; mIdle = 0; mWakeLeft = 0; mPtr = 0;
    mPend0 = 0; mPend1 = 0; mRead0 = 0; mRead1 = 0;
  endtask

  // Called just after a rising edge; drives one cycle, checks at the falling
  // edge, advances the model and returns just after the next rising edge.
  task automatic applyStimulus(
    input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [31:0] d0, input logic [3:0] b0,
    input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [31:0] d1, input logic [3:0] b1,
    input logic re);
    logic          anyReq;
    logic          eWe;
    logic [AW-1:0] eAddr;
    logic [31:0]   eWdata;
    logic [3:0]    eBe;
    p0Req = r0; p0We = w0; p0Addr = a0; p0Wdata = d0; p0Be = b0;
    p1Req = r1; p1We = w1; p1Addr = a1; p1Wdata = d1; p1Be = b1;
    retEn = re;
    memRdata = $urandom();
    #4;
    expGnt0 = 0; expGnt1 = 0;
    if (mMode == M_ACTIVE) begin
      if (r0 && r1) begin
        if (mPtr == 0) expGnt0 = 1; else expGnt1 = 1;
      end else begin
        expGnt0 = r0; expGnt1 = r1;
      end
    end
    eWe = 0; eAddr = '0; eWdata = '0; eBe = '0;
    if (expGnt0) begin eWe = w0; eAddr = a0; eWdata = d0; eBe = b0; end
    if (expGnt1) begin eWe = w1; eAddr = a1; eWdata = d1; eBe = b1; end
    checkOutput("gnt0", p0Gnt, expGnt0);
    checkOutput("gnt1", p1Gnt, expGnt1);
    checkOutput("mem_req", memReq, expGnt0 | expGnt1);
    checkOutput("mem_we", memWe, eWe);
    checkOutput("mem_addr", memAddr, eAddr);
    checkOutput("mem_wdata", memWdata, eWdata);
    checkOutput("mem_be", memBe, eBe);
    checkOutput("ret_no", memRetNo, mMode != M_RET);
    checkOutput("ret_state", retState, mMode != M_ACTIVE);
    checkOutput("rvalid0", p0Rvalid, mPend0);
    checkOutput("rvalid1", p1Rvalid, mPend1);
    checkOutput("rdata0", p0Rdata, (mPend0 && mRead0) ? memRdata : 32'h0);
    checkOutput("rdata1", p1Rdata, (mPend1 && mRead1) ? memRdata : 32'h0);
    lastGnt0 = p0Gnt; lastGnt1 = p1Gnt; lastRvalid0 = p0Rvalid; lastRvalid1 = p1Rvalid;
    lastRdata0 = p0Rdata; lastRdata1 = p1Rdata; lastMemRdata = memRdata;
    lastRetNo = memRetNo; lastRetState = retState; lastAddr = memAddr;
    // Advance the model by one cycle
    anyReq = r0 | r1;
    if (r0 && r1 && (expGnt0 || expGnt1)) mPtr = expGnt0 ? 1 : 0;
    case (mMode)
      M_ACTIVE: begin
        if (!anyReq && mIdle == IC && re && !mPend0 && !mPend1) mMode = M_RET;
        if (anyReq) mIdle = 0;
        else if (mIdle < IC) mIdle = mIdle + 1;
      end
      M_RET: begin
        if (anyReq || !re) begin mMode = M_WAKE; mWakeLeft = WC; end
      end
      default: begin
        if (anyReq) mIdle = 0;
        mWakeLeft = mWakeLeft - 1;
        if (mWakeLeft == 0) begin mMode = M_ACTIVE; mIdle = 0; end
      end
    endcase
    mPend0 = expGnt0; mRead0 = expGnt0 && !w0;
    mPend1 = expGnt1; mRead1 = expGnt1 && !w1;
    @(posedge clk); #1;
  endtask

  task automatic idleCycle(input logic re);
    applyStimulus(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, re);
  endtask

  // Asserts reset just after an edge, checks the reset values and releases
  // it just after the following edge.
  task automatic doReset();
    rst = 1;
    p0Req = 0; p0We = 0; p0Addr = '0; p0Wdata = '0; p0Be = '0;
    p1Req = 0; p1We = 0; p1Addr = '0; p1Wdata = '0; p1Be = '0;
    retEn = 0;
    #1;
    checkOutput("rst_gnt0", p0Gnt, 0);
    checkOutput("rst_gnt1", p1Gnt, 0);
    checkOutput("rst_rvalid0", p0Rvalid, 0);
    checkOutput("rst_rvalid1", p1Rvalid, 0);
    checkOutput("rst_rdata0", p0Rdata, 0);
    checkOutput("rst_mem_req", memReq, 0);
    checkOutput("rst_mem_addr", memAddr, 0);
    checkOutput("rst_ret_no", memRetNo, 1);
    checkOutput("rst_ret_state", retState, 0);
    modelReset();
    @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    logic [3:0] seq0, seq1;
    int firstRet, gntAt;
    bit hr0, hw0, hr1, hw1;
    logic [AW-1:0] ha0, ha1;
    logic [31:0] hd0, hd1;
    logic [3:0] hb0, hb1;
    bit quiet;
    logic re;

    modelReset();
    @(posedge clk); #1;
    doReset();

    // p0 read of 0x10 alone: same-cycle grant, response next cycle
    applyStimulus(1, 0, 10'h010, '0, 4'hF, 0, 0, '0, '0, '0, 1);
    checkOutput("s1_gnt0", lastGnt0, 1);
    checkOutput("s1_addr", lastAddr, 10'h010);
    idleCycle(1);
    checkOutput("s1_rvalid0", lastRvalid0, 1);
    checkOutput("s1_rdata0", lastRdata0, lastMemRdata);

    // Contention right after reset alternates p0, p1, p0, p1
    doReset();
    seq0 = '0; seq1 = '0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 10'h001, '0, 4'hF, 1, 0, 10'h002, '0, 4'hF, 1);
      seq0 = {seq0[2:0], lastGnt0};
      seq1 = {seq1[2:0], lastGnt1};
    end
    checkOutput("s2_seq_p0", seq0, 4'b1010);
    checkOutput("s2_seq_p1", seq1, 4'b0101);

    // Idle with retention allowed: bank enters retention on cycle 18
    doReset();
    firstRet = 0;
    for (int c = 1; c <= 18; c++) begin
      idleCycle(1);
      if (firstRet == 0 && lastRetNo === 1'b0) firstRet = c;
    end
    checkOutput("s3_ret_cycle", firstRet, 18);
    checkOutput("s3_ret_state", lastRetState, 1);

    // p1 write while retentive: two wake cycles, grant on the third
    gntAt = -1;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(0, 0, '0, '0, '0, 1, 1, 10'h155, 32'hA5A5_5A5A, 4'h3, 1);
      if (lastGnt1 === 1'b1) begin gntAt = k; break; end
    end
    checkOutput("s4_gnt1_delay", gntAt, 3);
    idleCycle(1);
    checkOutput("s4_rvalid1", lastRvalid1, 1);
    checkOutput("s4_rdata1", lastRdata1, 0);

    // Request on the threshold cycle wins over retention entry
    doReset();
    for (int c = 1; c <= 16; c++) idleCycle(1);
    applyStimulus(1, 0, 10'h020, '0, 4'hF, 0, 0, '0, '0, '0, 1);
    checkOutput("s5_gnt0", lastGnt0, 1);
    idleCycle(1);
    checkOutput("s5_ret_state", lastRetState, 0);
    checkOutput("s5_ret_no", lastRetNo, 1);

    // Reset the cycle after a read grant drops the response
    doReset();
    applyStimulus(1, 0, 10'h030, '0, 4'hF, 0, 0, '0, '0, '0, 1);
    checkOutput("s6_gnt0", lastGnt0, 1);
    doReset();
    idleCycle(1);
    checkOutput("s6_rvalid0", lastRvalid0, 0);

    // Bursty random traffic; requesters hold their command until granted
    doReset();
    hr0 = 0; hr1 = 0; hw0 = 0; hw1 = 0;
    ha0 = '0; ha1 = '0; hd0 = '0; hd1 = '0; hb0 = '0; hb1 = '0;
    for (int c = 0; c < 600; c++) begin
      quiet = ((c / 50) % 2) == 1;
      if (!hr0 && ($urandom_range(0, 99) < (quiet ? 1 : 40))) begin
        hr0 = 1; hw0 = $urandom_range(0, 1) == 1; ha0 = AW'($urandom());
        hd0 = $urandom(); hb0 = 4'($urandom());
      end
      if (!hr1 && ($urandom_range(0, 99) < (quiet ? 1 : 40))) begin
        hr1 = 1; hw1 = $urandom_range(0, 1) == 1; ha1 = AW'($urandom());
        hd1 = $urandom(); hb1 = 4'($urandom());
      end
      re = ($urandom_range(0, 15) != 0);
      applyStimulus(hr0, hw0, ha0, hd0, hb0, hr1, hw1, ha1, hd1, hb1, re);
      if (expGnt0) hr0 = 0;
      if (expGnt1) hr1 = 0;
    end
    idleCycle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
    $finish;
  end

endmodule
